// File: rtl/qdec_pkg.sv
// qdec_pkg
//   Shared definitions for the multi-channel quadrature decoder: per-channel
//   register word indices, CTRL/STATUS bit positions, the AXI response
//   encoding, the per-channel address stride and a byte-strobe merge helper.
//   No ports; imported by qdec_channel and quad_decoder_mc_axil.
package qdec_pkg;

  // Each channel owns four 32-bit words starting at n * CH_STRIDE.
  localparam int CH_STRIDE = 16;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  // Word index within a channel block (byte address bits [3:2]).
  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LATCH  = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_W        = 5;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_DIR_INV  = 1;
  localparam int CTRL_Z_CLR_EN = 2;
  localparam int CTRL_Z_LAT_EN = 3;
  localparam int CTRL_IRQ_EN   = 4;

  // STATUS bit positions; DIR is read-only, the rest are sticky W1C flags.
  localparam int STAT_DIR    = 0;
  localparam int STAT_ERR    = 1;
  localparam int STAT_Z_SEEN = 2;
  localparam int STAT_OVF    = 3;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // Replace only the bytes of old_val whose strobe bit is set.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/qdec_channel.sv
// qdec_channel
//   One encoder channel: 2-FF synchronisers and stability filters on A/B/Z,
//   x4 Gray-code decode, signed position counter, index latch and sticky
//   error/index/overflow flags.
// Ports
//   clk, reset           clock and synchronous active-high reset
//   enc_a/enc_b/enc_z    raw encoder inputs, asynchronous to clk
//   wr_count/wr_ctrl/wr_status  one-cycle register write strobes from the bus
//   wdata, wstrb         bus write data and byte strobes
//   count, latch         position counter and index-captured value
//   ctrl                 CTRL register contents
//   status               {ovf, z_seen, err, dir}
//   irq                  any sticky flag set while irq_en is set
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int COUNT_W  = 32,
  parameter int FILT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               enc_z,
  input  logic               wr_count,
  input  logic               wr_ctrl,
  input  logic               wr_status,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] latch,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [3:0]         status,
  output logic               irq
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  // Bit order in the input pipeline: [2]=A, [1]=B, [0]=Z.
  logic [2:0] sync_q1, sync_q2, filt;
  logic [3:0] filt_cnt [3];
  logic [1:0] ab_prev;
  logic       z_prev;
  logic       dir_q, err_q, z_seen_q, ovf_q;

  logic [1:0]         ab_now, ab_diff;
  logic               step_legal, step_illegal, step_up, do_step;
  logic               z_rise, index_clr, step_applied, wrap;
  logic [COUNT_W-1:0] count_step;
  logic [31:0]        count_merged;
  logic [3:0]         w1c;

  // Two-flop synchroniser for all three encoder inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {enc_a, enc_b, enc_z};
      sync_q2 <= sync_q1;
    end
  end

  // A filtered bit only follows the synchronised bit after it has differed
  // for FILT_LEN consecutive cycles; any return to the old value restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          filt[i]     <= sync_q2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Gray decode: forward order is 00->01->11->10. For a single-bit change the
  // step is forward exactly when previous A differs from the new B.
  always_comb begin
    ab_now       = filt[2:1];
    ab_diff      = ab_now ^ ab_prev;
    step_legal   = ^ab_diff;
    step_illegal = &ab_diff;
    step_up      = (ab_prev[1] ^ ab_now[0]) ^ ctrl[CTRL_DIR_INV];
    do_step      = step_legal & ctrl[CTRL_EN];
    z_rise       = filt[0] & ~z_prev;
    index_clr    = z_rise & ctrl[CTRL_Z_CLR_EN];
    step_applied = do_step & ~wr_count & ~index_clr;
    count_step   = step_up ? count + 1'b1 : count - 1'b1;
    wrap         = step_up ? (&count) : ~(|count);
    count_merged = merge_wstrb(32'(count), wdata, wstrb);
    w1c          = wr_status ? wdata[3:0] : 4'h0;
  end

  // The decode state always tracks the inputs, even while counting is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ab_prev <= '0;
      z_prev  <= 1'b0;
    end else begin
      ab_prev <= ab_now;
      z_prev  <= filt[0];
    end
  end

  // Counter priority: bus write, then index clear, then encoder step.
  // The latch takes the value from before this cycle's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      latch <= '0;
    end else begin
      if (wr_count)          count <= count_merged[COUNT_W-1:0];
      else if (index_clr)    count <= '0;
      else if (step_applied) count <= count_step;
      if (z_rise && ctrl[CTRL_Z_LAT_EN]) latch <= count;
    end
  end

  // CTRL register; all defined bits live in byte 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (wr_ctrl && wstrb[0]) begin
      ctrl <= wdata[CTRL_W-1:0];
    end
  end

  // Sticky flags: a hardware set in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      z_seen_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_step) dir_q <= step_up;
      err_q    <= (err_q    & ~w1c[STAT_ERR])    | step_illegal;
      z_seen_q <= (z_seen_q & ~w1c[STAT_Z_SEEN]) | z_rise;
      ovf_q    <= (ovf_q    & ~w1c[STAT_OVF])    | (step_applied & wrap);
    end
  end

  assign status = {ovf_q, z_seen_q, err_q, dir_q};
  assign irq    = ctrl[CTRL_IRQ_EN] & (err_q | z_seen_q | ovf_q);

endmodule

// File: rtl/quad_decoder_mc_axil.sv
// quad_decoder_mc_axil
//   Multi-channel quadrature decoder behind an AXI4-Lite slave. Each channel
//   has COUNT/CTRL/STATUS/LATCH words at base n*0x10.
// Ports
//   ACLK, ARESET          clock and synchronous active-high reset
//   enc_a/enc_b/enc_z     per-channel encoder inputs (asynchronous)
//   irq                   OR of every channel's enabled sticky flags
//   S_AXI_*               AXI4-Lite slave, 32-bit data, ADDR_W address;
//                         PROT is ignored and every response is OKAY
module quad_decoder_mc_axil
  import qdec_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int COUNT_W  = 32,
  parameter int FILT_LEN = 4,
  parameter int ADDR_W   = $clog2(NUM_CH * CH_STRIDE)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  input  logic [NUM_CH-1:0] enc_z,
  output logic              irq,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  logic aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [31:0] r_data_q, rd_mux;
  logic wr_fire, rd_fire;
  logic [ADDR_W-1:0] wr_ch, rd_ch;
  logic [1:0] wr_reg, rd_reg;

  logic [COUNT_W-1:0] ch_count  [NUM_CH];
  logic [COUNT_W-1:0] ch_latch  [NUM_CH];
  logic [CTRL_W-1:0]  ch_ctrl   [NUM_CH];
  logic [3:0]         ch_status [NUM_CH];
  logic [NUM_CH-1:0]  ch_irq;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = ar_ready_q & S_AXI_ARVALID;
  assign wr_ch   = S_AXI_AWADDR >> CH_SHIFT;
  assign rd_ch   = S_AXI_ARADDR >> CH_SHIFT;
  assign wr_reg  = S_AXI_AWADDR[3:2];
  assign rd_reg  = S_AXI_ARADDR[3:2];

  // Write channel: AWREADY/WREADY pulse together for one cycle once both
  // address and data are offered and no response is pending; the response
  // follows on the next cycle and is held until the master takes it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      aw_ready_q <= ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q;
      if (wr_fire)           b_valid_q <= 1'b1;
      else if (S_AXI_BREADY) b_valid_q <= 1'b0;
    end
  end

  // Read channel: data is captured at the address handshake and held until
  // RREADY, so RDATA cannot change under a stalled master.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      ar_ready_q <= ~ar_ready_q & S_AXI_ARVALID & ~r_valid_q;
      if (rd_fire) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // Read mux; addresses past the last channel match nothing and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == ADDR_W'(i)) begin
        case (rd_reg)
          REG_COUNT:  rd_mux = 32'(ch_count[i]);
          REG_CTRL:   rd_mux = 32'(ch_ctrl[i]);
          REG_STATUS: rd_mux = 32'(ch_status[i]);
          default:    rd_mux = 32'(ch_latch[i]);
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_sel;
    assign ch_sel = wr_fire && (wr_ch == ADDR_W'(i));

    qdec_channel #(
      .COUNT_W  (COUNT_W),
      .FILT_LEN (FILT_LEN)
    ) u_channel (
      .clk       (ACLK),
      .reset     (ARESET),
      .enc_a     (enc_a[i]),
      .enc_b     (enc_b[i]),
      .enc_z     (enc_z[i]),
      .wr_count  (ch_sel && (wr_reg == REG_COUNT)),
      .wr_ctrl   (ch_sel && (wr_reg == REG_CTRL)),
      .wr_status (ch_sel && (wr_reg == REG_STATUS)),
      .wdata     (S_AXI_WDATA),
      .wstrb     (S_AXI_WSTRB),
      .count     (ch_count[i]),
      .latch     (ch_latch[i]),
      .ctrl      (ch_ctrl[i]),
      .status    (ch_status[i]),
      .irq       (ch_irq[i])
    );
  end

  assign irq           = |ch_irq;
  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_quad_decoder_mc_axil.sv
// tb_quad_decoder_mc_axil
//   Directed bench for quad_decoder_mc_axil with four channels, 32-bit
//   counters and a 4-cycle filter. Inputs change on the falling clock edge
//   and outputs are sampled there too.
module tb_quad_decoder_mc_axil;

  localparam int NUM_CH    = 4;
  localparam int COUNT_W   = 32;
  localparam int FILT_LEN  = 4;
  localparam int ADDR_W    = 6;
  localparam int EDGE_CLKS = 20;
  localparam int TIMEOUT   = 100;

  localparam int OFF_COUNT  = 0;
  localparam int OFF_CTRL   = 4;
  localparam int OFF_STATUS = 8;
  localparam int OFF_LATCH  = 12;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NUM_CH-1:0] enc_a, enc_b, enc_z;
  logic              irq;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  always #5 aclk = ~aclk;

  quad_decoder_mc_axil #(
    .NUM_CH   (NUM_CH),
    .COUNT_W  (COUNT_W),
    .FILT_LEN (FILT_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .enc_z         (enc_z),
    .irq           (irq),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [ADDR_W-1:0] regAddr(input int ch, input int off);
    return ADDR_W'(ch * 16 + off);
  endfunction

  // Moves one channel by a number of quadrature edges; forward is 00->01->11->10.
  task automatic applyStimulus(input int ch, input bit fwd, input int edges);
    for (int e = 0; e < edges; e++) begin
      logic [1:0] cur, nxt;
      cur = {enc_a[ch], enc_b[ch]};
      if (fwd) begin
        case (cur)
          2'b00:   nxt = 2'b01;
          2'b01:   nxt = 2'b11;
          2'b11:   nxt = 2'b10;
          default: nxt = 2'b00;
        endcase
      end else begin
        case (cur)
          2'b00:   nxt = 2'b10;
          2'b10:   nxt = 2'b11;
          2'b11:   nxt = 2'b01;
          default: nxt = 2'b00;
        endcase
      end
      enc_a[ch] = nxt[1];
      enc_b[ch] = nxt[0];
      repeat (EDGE_CLKS) @(negedge aclk);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with the bus idle.
  task automatic axiWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < TIMEOUT) begin @(negedge aclk); n++; end
    checkOutput("aw_wait", 64'(n < TIMEOUT), 64'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < TIMEOUT) begin @(negedge aclk); n++; end
    checkOutput("b_wait", 64'(n < TIMEOUT), 64'd1);
    checkOutput("bresp", 64'(bresp), 64'd0);
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axiRead(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < TIMEOUT) begin @(negedge aclk); n++; end
    checkOutput("ar_wait", 64'(n < TIMEOUT), 64'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TIMEOUT) begin @(negedge aclk); n++; end
    checkOutput("r_wait", 64'(n < TIMEOUT), 64'd1);
    data = rdata;
    resp = rresp;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] expected);
    logic [31:0] d;
    logic [1:0]  r;
    axiRead(addr, d, r);
    checkOutput(tag, 64'(d), 64'(expected));
  endtask

  initial begin
    areset = 1'b1;
    enc_a = '0; enc_b = '0; enc_z = '0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    repeat (4) @(negedge aclk);
    checkOutput("reset_outputs",
                64'({awready, wready, arready, bvalid, rvalid, irq, bresp, rresp}), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // Every register word reads zero with OKAY after reset.
    for (int i = 0; i < 4 * NUM_CH; i++) begin
      axiRead(ADDR_W'(i * 4), rd_val, rd_resp);
      checkOutput($sformatf("reset_word_%0h", i * 4), 64'({rd_resp, rd_val}), 64'd0);
    end

    // Channel 0: 40 forward edges then 12 reverse edges.
    axiWrite(regAddr(0, OFF_CTRL), 32'h1, 4'hF);
    applyStimulus(0, 1'b1, 40);
    readCheck("ch0_count_fwd", regAddr(0, OFF_COUNT), 32'd40);
    readCheck("ch0_status_fwd", regAddr(0, OFF_STATUS), 32'h1);
    applyStimulus(0, 1'b0, 12);
    readCheck("ch0_count_rev", regAddr(0, OFF_COUNT), 32'd28);
    readCheck("ch0_status_rev", regAddr(0, OFF_STATUS), 32'h0);

    // Channel 1: wrap through zero sets ovf and raises irq; W1C clears it.
    axiWrite(regAddr(1, OFF_COUNT), 32'hFFFF_FFFE, 4'hF);
    axiWrite(regAddr(1, OFF_CTRL), 32'h11, 4'hF);
    applyStimulus(1, 1'b1, 3);
    readCheck("ch1_count_wrap", regAddr(1, OFF_COUNT), 32'h1);
    readCheck("ch1_status_ovf", regAddr(1, OFF_STATUS), 32'h9);
    checkOutput("irq_ovf", 64'(irq), 64'd1);
    axiWrite(regAddr(1, OFF_STATUS), 32'h8, 4'hF);
    readCheck("ch1_status_w1c", regAddr(1, OFF_STATUS), 32'h1);
    checkOutput("irq_cleared", 64'(irq), 64'd0);

    // Channel 2: index pulse latches and clears; a short glitch is filtered.
    axiWrite(regAddr(2, OFF_CTRL), 32'hD, 4'hF);
    readCheck("ch2_ctrl", regAddr(2, OFF_CTRL), 32'hD);
    applyStimulus(2, 1'b1, 17);
    readCheck("ch2_count_pre", regAddr(2, OFF_COUNT), 32'd17);
    enc_z[2] = 1'b1;
    repeat (10) @(negedge aclk);
    enc_z[2] = 1'b0;
    repeat (EDGE_CLKS) @(negedge aclk);
    readCheck("ch2_latch", regAddr(2, OFF_LATCH), 32'd17);
    readCheck("ch2_count_clr", regAddr(2, OFF_COUNT), 32'd0);
    readCheck("ch2_status_z", regAddr(2, OFF_STATUS), 32'h5);
    axiWrite(regAddr(2, OFF_STATUS), 32'h4, 4'hF);
    applyStimulus(2, 1'b1, 2);
    enc_z[2] = 1'b1;
    repeat (2) @(negedge aclk);
    enc_z[2] = 1'b0;
    repeat (EDGE_CLKS) @(negedge aclk);
    readCheck("ch2_glitch_count", regAddr(2, OFF_COUNT), 32'd2);
    readCheck("ch2_glitch_latch", regAddr(2, OFF_LATCH), 32'd17);
    readCheck("ch2_glitch_status", regAddr(2, OFF_STATUS), 32'h1);

    // Channel 3: both phases at once is an error with no step.
    axiWrite(regAddr(3, OFF_CTRL), 32'h1, 4'hF);
    applyStimulus(3, 1'b1, 2);
    enc_a[3] = 1'b0;
    enc_b[3] = 1'b0;
    repeat (EDGE_CLKS) @(negedge aclk);
    readCheck("ch3_count_illegal", regAddr(3, OFF_COUNT), 32'd2);
    readCheck("ch3_status_err", regAddr(3, OFF_STATUS), 32'h3);
    // The step reaches the counter seven cycles after the input change; the
    // write started five falling edges later hands-shakes on that same edge.
    enc_b[3] = 1'b1;
    repeat (5) @(negedge aclk);
    axiWrite(regAddr(3, OFF_COUNT), 32'h100, 4'hF);
    repeat (EDGE_CLKS) @(negedge aclk);
    readCheck("ch3_write_wins", regAddr(3, OFF_COUNT), 32'h100);
    axiWrite(regAddr(3, OFF_COUNT), 32'h0000_AB00, 4'b0010);
    readCheck("ch3_wstrb", regAddr(3, OFF_COUNT), 32'h0000_AB00);

    // Overlapping read and write with both responses stalled, then reset.
    awaddr = regAddr(0, OFF_CTRL); wdata = 32'h3; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = regAddr(0, OFF_COUNT); arvalid = 1'b1; rready = 1'b0;
    @(negedge aclk);
    checkOutput("overlap_ready", 64'({awready, wready, arready}), 64'h7);
    @(negedge aclk);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall_%0d", c),
                  64'({awready, wready, arready, bvalid, rvalid, rdata}),
                  64'({3'b000, 1'b1, 1'b1, 32'd28}));
      @(negedge aclk);
    end
    areset = 1'b1;
    @(negedge aclk);
    checkOutput("reset_mid_burst", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
    areset = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    readCheck("post_reset_ctrl0", regAddr(0, OFF_CTRL), 32'h0);
    readCheck("post_reset_count0", regAddr(0, OFF_COUNT), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
